// File: rtl/wb_mtimer.sv
// RISC-V machine timer on a Wishbone pipelined slave: prescaled 64-bit mtime,
// 64-bit mtimecmp, LO-first atomic mtime read through a hi shadow, level irq.
module wb_mtimer #(
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned ADDR_LSB_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        wb_stall,
    output logic        wb_err,
    output logic        irq_timer
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [31:0] hi_shadow_r;
    logic [15:0] ps_cnt_r;

    logic        req_s;
    logic        bad_s;
    logic        wr_s;
    logic        rd_s;
    logic        tick_s;
    logic [1:0]  idx_s;
    logic [31:0] rd_dat_s;
    logic        unused_adr_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // Request decode and read-data mux
    always_comb begin
        req_s        = wb_cyc & wb_stb;
        bad_s        = (wb_adr[1:0] != 2'b00);
        idx_s        = wb_adr[ADDR_LSB_W-1:2];
        wr_s         = req_s & ~bad_s & wb_we;
        rd_s         = req_s & ~bad_s & ~wb_we;
        tick_s       = (ps_cnt_r == PS_LAST);
        unused_adr_s = ^{wb_adr[31:ADDR_LSB_W]};
        case (idx_s)
            2'd0:    rd_dat_s = mtime_r[31:0];
            2'd1:    rd_dat_s = hi_shadow_r;
            2'd2:    rd_dat_s = mtimecmp_r[31:0];
            2'd3:    rd_dat_s = mtimecmp_r[63:32];
            default: rd_dat_s = 32'd0;
        endcase
    end

    // Timer state: a software write to either mtime word wins over the tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_r     <= 64'd0;
            mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
            hi_shadow_r <= 32'd0;
            ps_cnt_r    <= 16'd0;
            irq_timer   <= 1'b0;
        end else begin
            if (wr_s && idx_s == 2'd0) begin
                mtime_r[31:0] <= merge_bytes(mtime_r[31:0], wb_dat_i, wb_sel);
                ps_cnt_r      <= 16'd0;
            end else if (wr_s && idx_s == 2'd1) begin
                mtime_r[63:32] <= merge_bytes(mtime_r[63:32], wb_dat_i, wb_sel);
                ps_cnt_r       <= 16'd0;
            end else if (tick_s) begin
                mtime_r  <= mtime_r + 64'd1;
                ps_cnt_r <= 16'd0;
            end else begin
                ps_cnt_r <= ps_cnt_r + 16'd1;
            end

            if (wr_s && idx_s == 2'd2) begin
                mtimecmp_r[31:0] <= merge_bytes(mtimecmp_r[31:0], wb_dat_i, wb_sel);
            end else if (wr_s && idx_s == 2'd3) begin
                mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], wb_dat_i, wb_sel);
            end else begin
                mtimecmp_r <= mtimecmp_r;
            end

            // LO read snapshots the upper word so a following HI read is coherent
            if (rd_s && idx_s == 2'd0) begin
                hi_shadow_r <= mtime_r[63:32];
            end else begin
                hi_shadow_r <= hi_shadow_r;
            end

            irq_timer <= (mtime_r >= mtimecmp_r);
        end
    end

    // Bus response: single-cycle ack/err, read data captured only on good reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack <= req_s & ~bad_s;
            wb_err <= req_s & bad_s;
            if (rd_s) begin
                wb_dat_o <= rd_dat_s;
            end else begin
                wb_dat_o <= wb_dat_o;
            end
        end
    end

    assign wb_stall = 1'b0;

endmodule

// File: tb/tb_wb_mtimer.sv
// Randomised bench for wb_mtimer: two instances (PRESCALE 1 and 4) checked
// against an arithmetic model of mtime as a function of elapsed clock edges.
module tb_wb_mtimer;

    localparam logic [31:0] BASE = 32'h1002_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc0 = 1'b0, cyc1 = 1'b0;
    logic        stb = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] dat_w = 32'd0;
    logic [31:0] rdat0, rdat1;
    logic        ack0, ack1, stall0, stall1, err0, err1, irq0, irq1;

    always #5 clk = ~clk;

    wb_mtimer #(.PRESCALE(1), .ADDR_LSB_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wb_cyc(cyc0), .wb_stb(stb), .wb_we(we),
        .wb_adr(adr), .wb_sel(sel), .wb_dat_i(dat_w), .wb_dat_o(rdat0),
        .wb_ack(ack0), .wb_stall(stall0), .wb_err(err0), .irq_timer(irq0)
    );

    wb_mtimer #(.PRESCALE(4), .ADDR_LSB_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wb_cyc(cyc1), .wb_stb(stb), .wb_we(we),
        .wb_adr(adr), .wb_sel(sel), .wb_dat_i(dat_w), .wb_dat_o(rdat1),
        .wb_ack(ack1), .wb_stall(stall1), .wb_err(err1), .irq_timer(irq1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mtime(e) = a_val + (e - a_edge) / prescale
    longint      edge_n = 0;
    logic [63:0] a_val [2];
    longint      a_edge [2];
    logic [63:0] cmp_m [2];
    logic [31:0] shadow_m [2];
    int          ps_m [2];
    logic        mon_valid = 1'b0;
    logic        cond_prev [2];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mt(input int d, input longint e);
        return a_val[d] + 64'((e - a_edge[d]) / longint'(ps_m[d]));
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // irq after edge e must equal the compare of the model state after edge e-1
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            mon_valid = 1'b0;
        end else begin
            if (mon_valid) begin
                check_eq("irq0", irq0, cond_prev[0]);
                check_eq("irq1", irq1, cond_prev[1]);
            end
            for (int d = 0; d < 2; d++) cond_prev[d] = (mt(d, edge_n) >= cmp_m[d]);
            mon_valid = 1'b1;
        end
    end

    task automatic xfer(input int d, input logic w, input logic [31:0] adr_v,
                        input logic [3:0] sel_v, input logic [31:0] dat_v,
                        output logic [31:0] rd);
        logic [63:0] cur;
        logic        bad;
        logic [1:0]  idx;
        logic [31:0] exp_rd, prev_dat, got;
        longint      k;
        @(negedge clk);
        k        = edge_n + 1;
        cur      = mt(d, edge_n);
        bad      = (adr_v[1:0] != 2'b00);
        idx      = adr_v[3:2];
        prev_dat = (d == 1) ? rdat1 : rdat0;
        case (idx)
            2'd0:    exp_rd = cur[31:0];
            2'd1:    exp_rd = shadow_m[d];
            2'd2:    exp_rd = cmp_m[d][31:0];
            default: exp_rd = cmp_m[d][63:32];
        endcase
        if (!bad && w) begin
            case (idx)
                2'd0: begin a_val[d] = {cur[63:32], mrg(cur[31:0], dat_v, sel_v)}; a_edge[d] = k; end
                2'd1: begin a_val[d] = {mrg(cur[63:32], dat_v, sel_v), cur[31:0]}; a_edge[d] = k; end
                2'd2: cmp_m[d][31:0]  = mrg(cmp_m[d][31:0], dat_v, sel_v);
                default: cmp_m[d][63:32] = mrg(cmp_m[d][63:32], dat_v, sel_v);
            endcase
        end else if (!bad && idx == 2'd0) begin
            shadow_m[d] = cur[63:32];
        end
        if (d == 1) cyc1 = 1'b1; else cyc0 = 1'b1;
        stb = 1'b1; we = w; adr = adr_v; sel = sel_v; dat_w = dat_v;
        @(negedge clk);
        got = (d == 1) ? rdat1 : rdat0;
        check_eq($sformatf("ack d%0d a%h", d, adr_v), (d == 1) ? ack1 : ack0, !bad);
        check_eq($sformatf("err d%0d a%h", d, adr_v), (d == 1) ? err1 : err0, bad);
        check_eq("stall", (d == 1) ? stall1 : stall0, 1'b0);
        if (bad) check_eq("dat_hold", got, prev_dat);
        else if (!w) check_eq($sformatf("rdat d%0d a%h", d, adr_v), got, exp_rd);
        rd = got;
        cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check_eq("ack_one_cycle", (d == 1) ? (ack1 | err1) : (ack0 | err0), 1'b0);
    endtask

    task automatic do_reset(input logic with_req);
        @(negedge clk);
        rst_n = 1'b0;
        if (with_req) begin
            cyc0 = 1'b1; cyc1 = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
        end
        for (int d = 0; d < 2; d++) begin
            a_val[d] = 64'd0; a_edge[d] = edge_n + 1;
            cmp_m[d] = 64'hFFFF_FFFF_FFFF_FFFF; shadow_m[d] = 32'd0;
        end
        @(negedge clk);
        rst_n = 1'b1; cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0;
        check_eq("rst_ack", {ack0, ack1, err0, err1}, 4'd0);
        check_eq("rst_dat", {rdat0, rdat1}, 64'd0);
        check_eq("rst_irq", {irq0, irq1}, 2'd0);
        @(negedge clk);
        check_eq("rst_no_late_ack", {ack0, ack1, err0, err1}, 4'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] cur;
        ps_m[0] = 1; ps_m[1] = 4;
        for (int d = 0; d < 2; d++) begin
            a_val[d] = 64'd0; a_edge[d] = 0; cmp_m[d] = '1; shadow_m[d] = 32'd0;
            cond_prev[d] = 1'b0;
        end

        // 1: reset and free run at PRESCALE=1
        do_reset(1'b0);
        repeat (9) @(negedge clk);
        xfer(0, 1'b0, BASE + 32'h0, 4'hF, 32'd0, rd);
        check_eq("t1_range", (rd >= 32'd10 && rd <= 32'd12), 1'b1);
        check_eq("t1_irq", irq0, 1'b0);
        xfer(0, 1'b0, BASE + 32'hC, 4'hF, 32'd0, rd);

        // 2: PRESCALE=4
        xfer(1, 1'b1, BASE + 32'h0, 4'hF, 32'd0, rd);
        repeat (40) @(negedge clk);
        xfer(1, 1'b0, BASE + 32'h0, 4'hF, 32'd0, rd);
        check_eq("t2_range", (rd >= 32'd9 && rd <= 32'd11), 1'b1);

        // 3: atomic LO/HI read across a carry
        xfer(0, 1'b1, BASE + 32'h4, 4'hF, 32'd0, rd);
        xfer(0, 1'b1, BASE + 32'h0, 4'hF, 32'hFFFF_FFF0, rd);
        xfer(0, 1'b0, BASE + 32'h0, 4'hF, 32'd0, rd);
        repeat (30) @(negedge clk);
        xfer(0, 1'b0, BASE + 32'h4, 4'hF, 32'd0, rd);
        check_eq("t3_hi_shadow", rd, 32'd0);
        xfer(0, 1'b0, BASE + 32'h0, 4'hF, 32'd0, rd);
        xfer(0, 1'b0, BASE + 32'h4, 4'hF, 32'd0, rd);
        check_eq("t3_hi_after", rd, 32'd1);

        // 4: interrupt rise, fall on cmp raise, fall on wrap
        xfer(0, 1'b1, BASE + 32'h4, 4'hF, 32'd0, rd);
        xfer(0, 1'b1, BASE + 32'h0, 4'hF, 32'd0, rd);
        xfer(0, 1'b1, BASE + 32'hC, 4'hF, 32'd0, rd);
        cur = mt(0, edge_n);
        xfer(0, 1'b1, BASE + 32'h8, 4'hF, cur[31:0] + 32'd20, rd);
        check_eq("t4_irq_low", irq0, 1'b0);
        repeat (30) @(negedge clk);
        check_eq("t4_irq_high", irq0, 1'b1);
        xfer(0, 1'b1, BASE + 32'h8, 4'hF, 32'hFFFF_FFFF, rd);
        check_eq("t4_irq_fell", irq0, 1'b0);
        xfer(0, 1'b1, BASE + 32'h8, 4'hF, 32'h0000_0100, rd);
        xfer(0, 1'b1, BASE + 32'h4, 4'hF, 32'hFFFF_FFFF, rd);
        xfer(0, 1'b1, BASE + 32'h0, 4'hF, 32'hFFFF_FFE0, rd);
        check_eq("t4_irq_top", irq0, 1'b1);
        repeat (60) @(negedge clk);
        check_eq("t4_irq_wrap", irq0, 1'b0);

        // 5: byte lanes on reset-valued mtimecmp
        xfer(1, 1'b1, BASE + 32'h8, 4'b0101, 32'hAABB_CCDD, rd);
        xfer(1, 1'b0, BASE + 32'h8, 4'hF, 32'd0, rd);
        check_eq("t5_lanes", rd, 32'hFFBB_FFDD);

        // 6: misaligned access errors without side effects, reset drops ack
        xfer(1, 1'b1, BASE + 32'h6, 4'hF, 32'h1234_5678, rd);
        xfer(1, 1'b0, BASE + 32'h8, 4'hF, 32'd0, rd);
        check_eq("t6_no_change", rd, 32'hFFBB_FFDD);
        xfer(0, 1'b0, BASE + 32'h7, 4'hF, 32'd0, rd);
        do_reset(1'b1);

        // Random traffic against the model
        for (int i = 0; i < 120; i++) begin
            int unsigned d_r;
            logic [31:0] a_r;
            d_r = $urandom_range(0, 1);
            a_r = BASE | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 7) == 0) a_r = a_r | 32'($urandom_range(1, 3));
            xfer(int'(d_r), 1'($urandom_range(0, 1)), a_r, 4'($urandom), $urandom, rd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
